// File: rtl/sfq_tx_pkg.sv
// rtl/sfq_tx_pkg.sv - shared state encoding and parameter legality check for the SFQ pulse transmitter
package sfq_tx_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   function automatic bit params_ok(input int width, input int bit_cycles, input int gap_cycles);
      return (width >= 1) && (bit_cycles >= 2) && (bit_cycles % 2 == 0) && (gap_cycles >= 0);
   endfunction

endpackage

// File: rtl/sfq_slot_timer.sv
// rtl/sfq_slot_timer.sv - slot/bit counters producing slot start, mid-slot and final-slot strobes
module sfq_slot_timer #(
   parameter int WIDTH      = 8,
   parameter int BIT_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic run,
   output logic slot_start,
   output logic slot_mid,
   output logic last_slot
);

   localparam int CW = $clog2(BIT_CYCLES);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [CW-1:0] slot_cnt;
   logic [IW-1:0] bit_idx;
   logic          slot_end;
   logic          final_bit;

   assign slot_end   = (slot_cnt == CW'(BIT_CYCLES - 1));
   assign final_bit  = (bit_idx == IW'(WIDTH - 1));
   assign slot_start = run && (slot_cnt == '0);
   assign slot_mid   = run && (slot_cnt == CW'(BIT_CYCLES / 2));
   assign last_slot  = run && slot_end && final_bit;

   // The bit index parks on the final bit; the FSM leaves SHIFT on last_slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_cnt <= '0;
         bit_idx  <= '0;
      end else if (start) begin
         slot_cnt <= '0;
         bit_idx  <= '0;
      end else if (run) begin
         if (slot_end) begin
            slot_cnt <= '0;
            if (!final_bit) bit_idx <= bit_idx + 1'b1;
         end else begin
            slot_cnt <= slot_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sfq_pulse_tx.sv
// rtl/sfq_pulse_tx.sv - toggle-encoded SFQ data/clock frame transmitter with inter-frame gap
module sfq_pulse_tx
   import sfq_tx_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int BIT_CYCLES = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out,
   output logic             out_clk,
   output logic             busy,
   output logic             done
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   if (!params_ok(WIDTH, BIT_CYCLES, GAP_CYCLES)) begin : g_bad_params
      $error("sfq_pulse_tx: illegal WIDTH/BIT_CYCLES/GAP_CYCLES");
   end

   state_t           state, state_next;
   logic             done_next;
   logic             accept;
   logic [WIDTH-1:0] shreg;
   logic [GW-1:0]    gap_cnt;
   logic             gap_last;
   logic             slot_start, slot_mid, last_slot;

   assign in_ready = (state == IDLE);
   assign busy     = !in_ready;
   assign accept   = in_valid && in_ready;
   assign gap_last = (int'(gap_cnt) == GAP_CYCLES - 1);

   sfq_slot_timer #(
      .WIDTH      (WIDTH),
      .BIT_CYCLES (BIT_CYCLES)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .start      (accept),
      .run        (state == SHIFT),
      .slot_start (slot_start),
      .slot_mid   (slot_mid),
      .last_slot  (last_slot)
   );

   always_comb begin
      state_next = state;
      done_next  = 1'b0;
      case (state)
         IDLE:  if (in_valid) state_next = SHIFT;
         SHIFT: if (last_slot) begin
            if (GAP_CYCLES == 0) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end else begin
               state_next = GAP;
            end
         end
         GAP: if (gap_last) begin
            state_next = IDLE;
            done_next  = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   // Pulse lines are levels; each change is one pulse, so they are never re-zeroed between frames.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         done    <= 1'b0;
         out     <= 1'b0;
         out_clk <= 1'b0;
         shreg   <= '0;
         gap_cnt <= '0;
      end else begin
         state   <= state_next;
         done    <= done_next;
         gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
         if (accept) begin
            shreg <= in_data;
         end else if (slot_start) begin
            out   <= out ^ shreg[0];
            shreg <= shreg >> 1;
         end
         if (slot_mid) out_clk <= ~out_clk;
      end
   end

endmodule

// File: tb/tb_sfq_pulse_tx.sv
// tb/tb_sfq_pulse_tx.sv - directed self-checking bench for sfq_pulse_tx
module tb_sfq_pulse_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_a, data_b;
   logic       valid_a, valid_b;
   logic       ready_a, ready_b, out_a, out_b, oclk_a, oclk_b, busy_a, busy_b, done_a, done_b;

   int n_checks = 0;
   int n_fail   = 0;
   int sel      = 0;
   logic [63:0] to_v, tc_v, dn_v, rd_v, bz_v;

   always #5 clk = ~clk;

   sfq_pulse_tx dut_a (
      .clk(clk), .rst(rst), .in_data(data_a), .in_valid(valid_a), .in_ready(ready_a),
      .out(out_a), .out_clk(oclk_a), .busy(busy_a), .done(done_a)
   );

   sfq_pulse_tx #(.WIDTH(8), .BIT_CYCLES(4), .GAP_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst), .in_data(data_b), .in_valid(valid_b), .in_ready(ready_b),
      .out(out_b), .out_clk(oclk_b), .busy(busy_b), .done(done_b)
   );

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [4:0] obs();
      return sel ? {out_b, oclk_b, done_b, ready_b, busy_b} : {out_a, oclk_a, done_a, ready_a, busy_a};
   endfunction

   function automatic logic [63:0] every(input int first, input int step, input int cnt);
      logic [63:0] m = '0;
      for (int i = 0; i < cnt; i++) m[first + i * step] = 1'b1;
      return m;
   endfunction

   function automatic logic [63:0] span(input int lo, input int hi);
      logic [63:0] m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   // Bit n of each vector describes the DUT just after edge k+n (k = accept edge).
   task automatic capture(input int ncyc);
      logic [4:0] s, p;
      p = obs();
      to_v = '0; tc_v = '0; dn_v = '0; rd_v = '0; bz_v = '0;
      for (int n = 1; n <= ncyc; n++) begin
         @(posedge clk); #1;
         s = obs();
         to_v[n] = s[4] ^ p[4];
         tc_v[n] = s[3] ^ p[3];
         dn_v[n] = s[2];
         rd_v[n] = s[1];
         bz_v[n] = s[0];
         p = s;
      end
   endtask

   task automatic accept_a(input logic [7:0] d, input bit hold);
      data_a  = d;
      valid_a = 1'b1;
      @(posedge clk); #1;
      if (!hold) valid_a = 1'b0;
   endtask

   task automatic wait_ready_a();
      int n = 0;
      while (!ready_a && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("ready_timeout", 64'(ready_a), 64'd1);
   endtask

   localparam logic [63:0] A5_TOG = (64'd1 << 1) | (64'd1 << 9) | (64'd1 << 21) | (64'd1 << 29);

   initial begin
      rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; data_a = 8'h00; data_b = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("reset_a", 64'({out_a, oclk_a, done_a, busy_a, ready_a}), 64'b00001);
      check("reset_b", 64'({out_b, oclk_b, done_b, busy_b, ready_b}), 64'b00001);
      rst = 1'b0;

      // 0xA5; in_data wiggles while busy
      accept_a(8'hA5, 1'b0);
      data_a = 8'h3C;
      capture(36);
      check("a5_out", to_v, A5_TOG);
      check("a5_clk", tc_v, every(3, 4, 8));
      check("a5_done", dn_v, 64'd1 << 34);
      check("a5_ready", rd_v, span(34, 36));
      check("a5_busy", bz_v, ~rd_v & span(1, 36));

      accept_a(8'h00, 1'b0);
      capture(36);
      check("zero_out", to_v, 64'd0);
      check("zero_clk", tc_v, every(3, 4, 8));
      check("zero_done", dn_v, 64'd1 << 34);

      // valid held: second frame accepted on the done cycle
      accept_a(8'hFF, 1'b1);
      data_a = 8'h01;
      capture(40);
      valid_a = 1'b0;
      check("b2b_out", to_v, every(1, 4, 8) | (64'd1 << 36));
      check("b2b_clk", tc_v, every(3, 4, 8) | (64'd1 << 38));
      check("b2b_done", dn_v, 64'd1 << 34);
      check("b2b_ready", rd_v, 64'd1 << 34);
      wait_ready_a();
      check("level_persist", 64'(out_a), 64'd1);

      accept_a(8'h01, 1'b0);
      capture(36);
      check("one_out", to_v, 64'd1 << 1);
      check("one_done", dn_v, 64'd1 << 34);

      // reset mid-frame, right after edge k+10
      accept_a(8'hFF, 1'b0);
      capture(9);
      check("pre_rst_out", to_v, every(1, 4, 3));
      check("pre_rst_level", 64'(out_a), 64'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("rst_async", 64'({out_a, oclk_a, done_a, busy_a, ready_a}), 64'b00001);
      @(posedge clk); #1;
      rst = 1'b0;
      accept_a(8'hA5, 1'b0);
      capture(36);
      check("post_rst_out", to_v, A5_TOG);
      check("post_rst_clk", tc_v, every(3, 4, 8));
      check("post_rst_done", dn_v, 64'd1 << 34);

      // GAP_CYCLES = 0 instance
      sel = 1;
      data_b = 8'h80;
      valid_b = 1'b1;
      @(posedge clk); #1;
      valid_b = 1'b0;
      capture(34);
      check("gap0_out", to_v, 64'd1 << 29);
      check("gap0_clk", tc_v, every(3, 4, 8));
      check("gap0_done", dn_v, 64'd1 << 32);
      check("gap0_ready", rd_v, span(32, 34));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
